trap_sequencer: RTL and testbench

//  Sits directly downstream of interrupt_ctrl and consumes its trap/mcause/mepc/mbadaddr outputs.

---
 rtl/trap_sequencer_if.sv | 37 +++
 rtl/trap_sequencer.sv | 145 ++++++++++++++
 tb/tb_trap_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// Bundle of trap, CSR and redirect signals between interrupt_ctrl/software,
// the trap sequencer and the fetch stage.
// master: drives trap/mret/CSR requests and redirect_ready (environment side).
// slave : the trap sequencer itself.
interface trap_sequencer_if;
   logic        trap_req;
   logic [31:0] trap_cause;
   logic [31:0] trap_epc;
   logic [31:0] trap_badaddr;
   logic        mret_req;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] mstatus;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mbadaddr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        busy;

   modport master (
      output trap_req, trap_cause, trap_epc, trap_badaddr, mret_req,
             csr_we, csr_addr, csr_wdata, redirect_ready,
      input  mstatus, mtvec, mepc, mcause, mbadaddr,
             redirect_valid, redirect_pc, busy
   );

   modport slave (
      input  trap_req, trap_cause, trap_epc, trap_badaddr, mret_req,
             csr_we, csr_addr, csr_wdata, redirect_ready,
      output mstatus, mtvec, mepc, mcause, mbadaddr,
             redirect_valid, redirect_pc, busy
   );
endinterface

// File: rtl/trap_sequencer.sv
// Machine trap sequencer: owns mstatus/mtvec/mepc/mcause/mbadaddr, performs
// trap entry (IDLE -> SAVE -> REDIRECT) and mret exit (IDLE -> REDIRECT), and
// hands the fetch stage a redirect PC over a valid/ready handshake.
// Optional feature macro: VECTORED_MTVEC_EN enables vectored mtvec mode
// (interrupts jump to base + 4*cause); without it mtvec[1:0] is hardwired 00.
module trap_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          NUM_VEC      = 16
) (
   input logic             clk,
   input logic             resetn,
   trap_sequencer_if.slave bus
);

   localparam int          IDX_W          = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MBADADDR  = 12'h343;
   localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;
`ifdef VECTORED_MTVEC_EN
   localparam logic [31:0] MTVEC_RST      = RESET_VECTOR;
`else
   localparam logic [31:0] MTVEC_RST      = RESET_VECTOR & WORD_MASK;
`endif

   typedef enum logic [1:0] {IDLE, SAVE, REDIRECT} state_t;

   state_t      state_q;
   logic [31:0] causeLat_q;
   logic [31:0] epcLat_q;
   logic [31:0] badLat_q;
   logic        mie_q;
   logic        mpie_q;
   logic [1:0]  mpp_q;
   logic [31:0] mtvec_q;
   logic [31:0] mtvec_d;
   logic [31:0] mepc_q;
   logic [31:0] mcause_q;
   logic [31:0] mbadaddr_q;
   logic        redirValid_q;
   logic [31:0] redirPc_q;
   logic [31:0] mtvecWrite;
   logic [31:0] trapTarget;

   // Software-visible mtvec value and the trap target derived from the current mtvec
   always_comb begin
`ifdef VECTORED_MTVEC_EN
      mtvecWrite = {bus.csr_wdata[31:2], (bus.csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00};
`else
      mtvecWrite = bus.csr_wdata & WORD_MASK;
`endif
      mtvec_d = mtvec_q;
      if (bus.csr_we && (bus.csr_addr == ADDR_MTVEC)) begin
         mtvec_d = mtvecWrite;
      end
      trapTarget = mtvec_q & WORD_MASK;
`ifdef VECTORED_MTVEC_EN
      if ((mtvec_q[1:0] == 2'b01) && causeLat_q[31]) begin
         trapTarget = (mtvec_q & WORD_MASK)
                    + {{(30 - IDX_W){1'b0}}, causeLat_q[IDX_W-1:0], 2'b00};
      end
`endif
   end

   // Sequencer FSM and CSR file; hardware trap/mret updates are written last so they win over software
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         causeLat_q   <= 32'h0;
         epcLat_q     <= 32'h0;
         badLat_q     <= 32'h0;
         mie_q        <= 1'b0;
         mpie_q       <= 1'b0;
         mpp_q        <= 2'b11;
         mtvec_q      <= MTVEC_RST;
         mepc_q       <= 32'h0;
         mcause_q     <= 32'h0;
         mbadaddr_q   <= 32'h0;
         redirValid_q <= 1'b0;
         redirPc_q    <= 32'h0;
      end else begin
         mtvec_q <= mtvec_d;
         if (bus.csr_we) begin
            case (bus.csr_addr)
               ADDR_MSTATUS: begin
                  mpp_q  <= bus.csr_wdata[12:11];
                  mpie_q <= bus.csr_wdata[7];
                  mie_q  <= bus.csr_wdata[3];
               end
               ADDR_MEPC:     mepc_q     <= bus.csr_wdata & WORD_MASK;
               ADDR_MCAUSE:   mcause_q   <= bus.csr_wdata;
               ADDR_MBADADDR: mbadaddr_q <= bus.csr_wdata;
               default: ;
            endcase
         end
         case (state_q)
            IDLE: begin
               if (bus.trap_req) begin
                  causeLat_q <= bus.trap_cause;
                  epcLat_q   <= bus.trap_epc;
                  badLat_q   <= bus.trap_badaddr;
                  state_q    <= SAVE;
               end else if (bus.mret_req) begin
                  mie_q        <= mpie_q;
                  mpie_q       <= 1'b1;
                  mpp_q        <= 2'b11;
                  redirPc_q    <= mepc_q;
                  redirValid_q <= 1'b1;
                  state_q      <= REDIRECT;
               end
            end
            SAVE: begin
               mepc_q       <= epcLat_q & WORD_MASK;
               mcause_q     <= causeLat_q;
               mbadaddr_q   <= badLat_q;
               mpie_q       <= mie_q;
               mie_q        <= 1'b0;
               mpp_q        <= 2'b11;
               redirPc_q    <= trapTarget;
               redirValid_q <= 1'b1;
               state_q      <= REDIRECT;
            end
            REDIRECT: begin
               if (bus.redirect_ready) begin
                  redirValid_q <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mstatus        = {19'h0, mpp_q, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
   assign bus.mtvec          = mtvec_q;
   assign bus.mepc           = mepc_q;
   assign bus.mcause         = mcause_q;
   assign bus.mbadaddr       = mbadaddr_q;
   assign bus.redirect_valid = redirValid_q;
   assign bus.redirect_pc    = redirPc_q;
   assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: CSR values checked with immediate
// assertions, redirect PCs checked through a scoreboard queue that is filled
// when a trap/mret is driven and drained on each valid/ready handshake.
module tb_trap_sequencer;

   logic clk;
   logic resetn;
   int   compared;
   int   mismatched;
   logic [31:0] sbQ[$];

   trap_sequencer_if tsIf ();

   trap_sequencer #(
      .RESET_VECTOR (32'h0000_0100),
      .NUM_VEC      (16)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (tsIf.slave)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
         $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of requests, step past the next rising edge, then drop the pulses
   task automatic applyStimulus(input logic trap, input logic mret, input logic [31:0] cause,
                                input logic [31:0] epc, input logic [31:0] bad,
                                input logic we, input logic [11:0] addr, input logic [31:0] wdata);
      tsIf.trap_req     = trap;
      tsIf.mret_req     = mret;
      tsIf.trap_cause   = cause;
      tsIf.trap_epc     = epc;
      tsIf.trap_badaddr = bad;
      tsIf.csr_we       = we;
      tsIf.csr_addr     = addr;
      tsIf.csr_wdata    = wdata;
      @(posedge clk);
      #1;
      tsIf.trap_req = 1'b0;
      tsIf.mret_req = 1'b0;
      tsIf.csr_we   = 1'b0;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic csrWrite(input logic [11:0] addr, input logic [31:0] wdata);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, addr, wdata);
   endtask

   // Scoreboard: on every handshake seen mid-cycle, pop and compare the redirect PC
   always @(negedge clk) begin
      if (resetn && tsIf.redirect_valid && tsIf.redirect_ready) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_redirect", tsIf.redirect_pc, 32'hxxxx_xxxx);
         end else begin
            checkOutput("redirect_pc_sb", tsIf.redirect_pc, sbQ.pop_front());
         end
      end
   end

   // Directed sequence
   initial begin
      compared   = 0;
      mismatched = 0;
      resetn     = 1'b0;
      tsIf.trap_req       = 1'b0;
      tsIf.mret_req       = 1'b0;
      tsIf.trap_cause     = 32'h0;
      tsIf.trap_epc       = 32'h0;
      tsIf.trap_badaddr   = 32'h0;
      tsIf.csr_we         = 1'b0;
      tsIf.csr_addr       = 12'h0;
      tsIf.csr_wdata      = 32'h0;
      tsIf.redirect_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_mtvec",   tsIf.mtvec,          32'h0000_0100);
      checkOutput("rst_mstatus", tsIf.mstatus,        32'h0000_1800);
      checkOutput("rst_valid",   {31'h0, tsIf.redirect_valid}, 32'h0);
      checkOutput("rst_busy",    {31'h0, tsIf.busy},  32'h0);
      checkOutput("rst_mepc",    tsIf.mepc,           32'h0);
      resetn = 1'b1;
      idleCycle();

      // Set MIE and mtvec
      csrWrite(12'h300, 32'h0000_1808);
      csrWrite(12'h305, 32'h0000_0200);
      checkOutput("cfg_mstatus", tsIf.mstatus, 32'h0000_1808);
      checkOutput("cfg_mtvec",   tsIf.mtvec,   32'h0000_0200);

      // Exception entry
      sbQ.push_back(32'h0000_0200);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h402, 32'h402, 1'b0, 12'h0, 32'h0);
      checkOutput("exc_busy_n1",  {31'h0, tsIf.busy},           32'h1);
      checkOutput("exc_valid_n1", {31'h0, tsIf.redirect_valid}, 32'h0);
      idleCycle();
      checkOutput("exc_valid_n2", {31'h0, tsIf.redirect_valid}, 32'h1);
      checkOutput("exc_pc",       tsIf.redirect_pc, 32'h0000_0200);
      checkOutput("exc_mepc",     tsIf.mepc,        32'h0000_0400);
      checkOutput("exc_mcause",   tsIf.mcause,      32'h0);
      checkOutput("exc_mbad",     tsIf.mbadaddr,    32'h0000_0402);
      checkOutput("exc_mstatus",  tsIf.mstatus,     32'h0000_1880);
      idleCycle();
      checkOutput("exc_done_busy", {31'h0, tsIf.busy}, 32'h0);

      // mret
      sbQ.push_back(32'h0000_0400);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
      checkOutput("mret_valid",   {31'h0, tsIf.redirect_valid}, 32'h1);
      checkOutput("mret_pc",      tsIf.redirect_pc, 32'h0000_0400);
      checkOutput("mret_mstatus", tsIf.mstatus,     32'h0000_1888);
      idleCycle();

      // Handshake stall with a second trap mid-stall
      tsIf.redirect_ready = 1'b0;
      sbQ.push_back(32'h0000_0200);
      applyStimulus(1'b1, 1'b0, 32'h5, 32'h500, 32'h0, 1'b0, 12'h0, 32'h0);
      idleCycle();
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            applyStimulus(1'b1, 1'b0, 32'h7, 32'h900, 32'h44, 1'b0, 12'h0, 32'h0);
         end else begin
            idleCycle();
         end
         checkOutput("stall_valid", {31'h0, tsIf.redirect_valid}, 32'h1);
         checkOutput("stall_pc",    tsIf.redirect_pc,  32'h0000_0200);
         checkOutput("stall_busy",  {31'h0, tsIf.busy}, 32'h1);
      end
      checkOutput("stall_mepc",   tsIf.mepc,   32'h0000_0500);
      checkOutput("stall_mcause", tsIf.mcause, 32'h5);
      tsIf.redirect_ready = 1'b1;
      idleCycle();
      checkOutput("stall_release_busy", {31'h0, tsIf.busy}, 32'h0);
      idleCycle();
      checkOutput("stall_no_reentry", {31'h0, tsIf.busy}, 32'h0);

      // Collision: trap+mret together, then software mstatus write in the SAVE cycle
      csrWrite(12'h300, 32'h0000_1808);
      checkOutput("col_pre_mstatus", tsIf.mstatus, 32'h0000_1808);
      sbQ.push_back(32'h0000_0200);
      applyStimulus(1'b1, 1'b1, 32'h3, 32'h604, 32'h10, 1'b0, 12'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 12'h300, 32'h8);
      checkOutput("col_mstatus", tsIf.mstatus, 32'h0000_1880);
      checkOutput("col_mepc",    tsIf.mepc,    32'h0000_0604);
      checkOutput("col_mcause",  tsIf.mcause,  32'h3);
      checkOutput("col_pc",      tsIf.redirect_pc, 32'h0000_0200);
      idleCycle();

      // mepc write masks low bits; mret returns there
      csrWrite(12'h341, 32'h0000_1237);
      checkOutput("mepc_mask", tsIf.mepc, 32'h0000_1234);
      sbQ.push_back(32'h0000_1234);
      applyStimulus(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 12'h0, 32'h0);
      checkOutput("mret2_pc", tsIf.redirect_pc, 32'h0000_1234);
      idleCycle();

      // mtvec mode bits and interrupt/exception targets
      csrWrite(12'h305, 32'h0000_0301);
`ifdef VECTORED_MTVEC_EN
      checkOutput("vec_mtvec", tsIf.mtvec, 32'h0000_0301);
      sbQ.push_back(32'h0000_031C);
`else
      checkOutput("vec_mtvec", tsIf.mtvec, 32'h0000_0300);
      sbQ.push_back(32'h0000_0300);
`endif
      applyStimulus(1'b1, 1'b0, 32'h8000_0007, 32'h700, 32'h0, 1'b0, 12'h0, 32'h0);
      idleCycle();
`ifdef VECTORED_MTVEC_EN
      checkOutput("vec_irq_pc", tsIf.redirect_pc, 32'h0000_031C);
`else
      checkOutput("vec_irq_pc", tsIf.redirect_pc, 32'h0000_0300);
`endif
      idleCycle();
      sbQ.push_back(32'h0000_0300);
      applyStimulus(1'b1, 1'b0, 32'h2, 32'h704, 32'h0, 1'b0, 12'h0, 32'h0);
      idleCycle();
      checkOutput("vec_exc_pc", tsIf.redirect_pc, 32'h0000_0300);
      idleCycle();

      // Reset in the middle of a trap entry drops it
      applyStimulus(1'b1, 1'b0, 32'h4, 32'h800, 32'h0, 1'b0, 12'h0, 32'h0);
      resetn = 1'b0;
      #1;
      checkOutput("midrst_busy",    {31'h0, tsIf.busy},           32'h0);
      checkOutput("midrst_valid",   {31'h0, tsIf.redirect_valid}, 32'h0);
      checkOutput("midrst_mtvec",   tsIf.mtvec,   32'h0000_0100);
      checkOutput("midrst_mstatus", tsIf.mstatus, 32'h0000_1800);
      @(posedge clk);
      #3;
      resetn = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_idle", {31'h0, tsIf.busy}, 32'h0);

      // First trap after reset goes to the reset vector
      sbQ.push_back(32'h0000_0100);
      applyStimulus(1'b1, 1'b0, 32'h1, 32'hA00, 32'h0, 1'b0, 12'h0, 32'h0);
      idleCycle();
      checkOutput("post_rst_pc", tsIf.redirect_pc, 32'h0000_0100);
      idleCycle();
      idleCycle();

      checkOutput("sb_drained", sbQ.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
